// File: rtl/led_matrix_pkg.sv
// Shared definitions for the 4x4 LED matrix: slot indexing, row/column fields
// and the frame sequencer state encoding.
package led_matrix_pkg;

    localparam int N_LEDS  = 16;
    localparam int IDX_W   = 4;
    localparam int ROW_LSB = 2;
    localparam int ROW_W   = 2;
    localparam int COL_LSB = 0;
    localparam int COL_W   = 2;

    typedef logic [IDX_W-1:0]  led_idx_t;
    typedef logic [N_LEDS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        BLANK
    } scan_state_e;

    function automatic logic [ROW_W-1:0] led_row(input led_idx_t idx);
        return idx[ROW_LSB +: ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] led_col(input led_idx_t idx);
        return idx[COL_LSB +: COL_W];
    endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Frame upload handshake: the upstream pushes one 16-bit frame per
// valid & ready beat into the sequencer's pending buffer.
interface led_scan_ctrl_if;
    import led_matrix_pkg::*;

    logic   frame_valid;
    frame_t frame_data;
    logic   frame_ready;

    modport master (output frame_valid, output frame_data, input frame_ready);
    modport slave  (input frame_valid, input frame_data, output frame_ready);

endinterface

// File: rtl/scan_slot_timer.sv
// Loadable down-counter: load_i arms it for CYCLES clocks, tc_o flags the
// final counted cycle and near_tc_o the cycle just before it.
module scan_slot_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    input  logic load_i,
    output logic tc_o,
    output logic near_tc_o
);

    localparam int               CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default first, so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates keep every flop sampling pre-edge values.
        if (!rst_n || clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o      = en_i && (cnt_q == '0);
    assign near_tc_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/led_scan_ctrl.sv
// Frame-level sequencer for the 4x4 LED scanner: double-buffers incoming
// frames and swaps them in only at a frame boundary.
module led_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 2,
    parameter int MIN_REPEAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    led_scan_ctrl_if.slave        frame_if,
    output logic                  data_led,
    output logic [IDX_W-1:0]      led_idx,
    output logic                  slot_start,
    output logic                  frame_done,
    output logic                  busy
);

    localparam led_idx_t         LAST_IDX = led_idx_t'(N_LEDS - 1);
    localparam int               REP_W    = (MIN_REPEAT > 1) ? $clog2(MIN_REPEAT + 1) : 1;
    localparam logic [REP_W-1:0] REP_SAT  = REP_W'(MIN_REPEAT);
    localparam logic [REP_W-1:0] REP_THR  = REP_W'(MIN_REPEAT - 1);

    scan_state_e      state_q, state_d;
    frame_t           active_q, active_d;
    frame_t           pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    led_idx_t         led_idx_q, led_idx_d;
    logic             data_led_q, data_led_d;
    logic             slot_start_q, slot_start_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic             frame_ready_q, frame_ready_d;

    logic dwell_load, dwell_tc, dwell_near_tc;
    logic blank_load, blank_tc, blank_near_tc;
    logic transfer;
    logic rep_ok;

    scan_slot_timer #(.CYCLES(DWELL_CYCLES)) u_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .en_i      (state_q == SCAN),
        .load_i    (dwell_load),
        .tc_o      (dwell_tc),
        .near_tc_o (dwell_near_tc)
    );

    scan_slot_timer #(.CYCLES(BLANK_CYCLES)) u_blank (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .en_i      (state_q == BLANK),
        .load_i    (blank_load),
        .tc_o      (blank_tc),
        .near_tc_o (blank_near_tc)
    );

    assign transfer = frame_if.frame_valid && frame_ready_q;
    // rep_cnt saturates at MIN_REPEAT, so "rep_cnt+1 >= MIN_REPEAT" is one of two values.
    assign rep_ok   = (rep_cnt_q == REP_THR) || (rep_cnt_q == REP_SAT);

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        rep_cnt_d      = rep_cnt_q;
        led_idx_d      = led_idx_q;
        slot_start_d   = 1'b0;
        frame_done_d   = 1'b0;
        dwell_load     = 1'b0;
        blank_load     = 1'b0;

        if (transfer) begin
            pending_d      = frame_if.frame_data;
            pending_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pending_full_q) begin
                    active_d       = pending_q;
                    pending_full_d = 1'b0;
                    rep_cnt_d      = '0;
                    state_d        = SCAN;
                    led_idx_d      = '0;
                    slot_start_d   = 1'b1;
                    dwell_load     = 1'b1;
                end
            end
            SCAN: begin
                if (dwell_tc) begin
                    if (led_idx_q == LAST_IDX) begin
                        state_d      = BLANK;
                        blank_load   = 1'b1;
                        frame_done_d = (BLANK_CYCLES == 1);
                    end else begin
                        led_idx_d    = led_idx_q + led_idx_t'(1);
                        slot_start_d = 1'b1;
                        dwell_load   = 1'b1;
                    end
                end
            end
            BLANK: begin
                if (blank_tc) begin
                    state_d      = SCAN;
                    led_idx_d    = '0;
                    slot_start_d = 1'b1;
                    dwell_load   = 1'b1;
                    if (pending_full_q && rep_ok) begin
                        active_d       = pending_q;
                        pending_full_d = 1'b0;
                        rep_cnt_d      = '0;
                    end else if (rep_cnt_q != REP_SAT) begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end else begin
                    frame_done_d = blank_near_tc;
                end
            end
            default: state_d = IDLE;
        endcase

        data_led_d    = (state_d == SCAN) && active_d[led_idx_d];
        busy_d        = (state_d != IDLE);
        frame_ready_d = !pending_full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            // NOTE: the frame buffers are reset too, so a flushed frame can never reappear.
            state_q        <= IDLE;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            rep_cnt_q      <= '0;
            led_idx_q      <= '0;
            data_led_q     <= 1'b0;
            slot_start_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            frame_ready_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            rep_cnt_q      <= rep_cnt_d;
            led_idx_q      <= led_idx_d;
            data_led_q     <= data_led_d;
            slot_start_q   <= slot_start_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
            frame_ready_q  <= frame_ready_d;
        end
    end

    assign frame_if.frame_ready = frame_ready_q;
    assign data_led             = data_led_q;
    assign led_idx              = led_idx_q;
    assign slot_start           = slot_start_q;
    assign frame_done           = frame_done_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with DWELL=2, BLANK=1, MIN_REPEAT=2
// (frame period 33 clocks); expected values are worked out by hand.
module tb_led_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       data_led;
    logic [3:0] led_idx;
    logic       slot_start;
    logic       frame_done;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] src_q [$];

    // Bits of 16'hA5C3 for idx 0..15.
    bit exp_a5c3 [16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

    led_scan_ctrl_if frame_if ();

    led_scan_ctrl #(
        .DWELL_CYCLES (2),
        .BLANK_CYCLES (1),
        .MIN_REPEAT   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .frame_if   (frame_if),
        .data_led   (data_led),
        .led_idx    (led_idx),
        .slot_start (slot_start),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        check(tag, busy, 1);
    endtask

    // Upstream model: presents the head of src_q and holds it until accepted.
    initial begin : source
        bit hs;
        frame_if.frame_valid = 1'b0;
        frame_if.frame_data  = '0;
        forever begin
            @(negedge clk);
            hs = frame_if.frame_valid && frame_if.frame_ready && rst_n && !clear;
            @(posedge clk);
            #2;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                frame_if.frame_valid = 1'b1;
                frame_if.frame_data  = src_q[0];
            end else begin
                frame_if.frame_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int fd_cnt;
        int busy_cnt;
        int n;

        rst_n = 1'b0;
        clear = 1'b0;

        // Reset and idle.
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("rst_ready", frame_if.frame_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_data_led", data_led, 0);
        check("rst_led_idx", led_idx, 0);
        check("rst_slot_start", slot_start, 0);
        check("rst_frame_done", frame_done, 0);

        // Single frame: one full scan and the start of the repeat.
        src_q.push_back(16'hA5C3);
        wait_busy("a5c3_start");
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 2; j++) begin
                check($sformatf("a5c3_idx_%0d_%0d", i, j), led_idx, i);
                check($sformatf("a5c3_led_%0d_%0d", i, j), data_led, exp_a5c3[i]);
                check($sformatf("a5c3_ss_%0d_%0d", i, j), slot_start, (j == 0));
                tick();
            end
        end
        check("a5c3_frame_done", frame_done, 1);
        check("a5c3_blank_led", data_led, 0);
        check("a5c3_blank_busy", busy, 1);
        tick();
        check("a5c3_rpt_done_low", frame_done, 0);
        check("a5c3_rpt_ss", slot_start, 1);
        check("a5c3_rpt_idx", led_idx, 0);
        check("a5c3_rpt_led", data_led, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr1_busy", busy, 0);
        check("clr1_ready", frame_if.frame_ready, 1);

        // Backpressure and MIN_REPEAT hold: F1, F2, F3 back to back.
        src_q.push_back(16'h0001);
        src_q.push_back(16'h8000);
        src_q.push_back(16'hFFFF);
        wait_busy("bp_start");                           // after E1
        check("bp_e1_ss", slot_start, 1);
        check("bp_e1_led", data_led, 1);
        check("bp_e1_ready", frame_if.frame_ready, 1);
        tick();                                          // E2: F2 accepted
        check("bp_e2_ready", frame_if.frame_ready, 0);
        check("bp_e2_led", data_led, 1);
        check("bp_e2_ss", slot_start, 0);
        tick();                                          // E3
        check("bp_e3_idx", led_idx, 1);
        check("bp_e3_led", data_led, 0);
        tick(30);                                        // E33: first frame_done
        check("bp_e33_done", frame_done, 1);
        check("bp_e33_ready", frame_if.frame_ready, 0);
        tick();                                          // E34: F1 repeats
        check("bp_e34_idx", led_idx, 0);
        check("bp_e34_led_f1", data_led, 1);
        check("bp_e34_ready", frame_if.frame_ready, 0);
        tick(32);                                        // E66: second frame_done
        check("bp_e66_done", frame_done, 1);
        check("bp_e66_ready", frame_if.frame_ready, 0);
        tick();                                          // E67: F2 swapped in
        check("bp_e67_ss", slot_start, 1);
        check("bp_e67_led_f2", data_led, 0);
        check("bp_e67_ready", frame_if.frame_ready, 1);
        tick();                                          // E68: F3 accepted
        check("bp_e68_ready", frame_if.frame_ready, 0);
        tick(29);                                        // E97: slot 15 of F2
        check("bp_e97_idx", led_idx, 15);
        check("bp_e97_led_f2", data_led, 1);
        tick(2);                                         // E99
        check("bp_e99_done", frame_done, 1);
        tick();                                          // E100: F2 repeats
        check("bp_e100_idx", led_idx, 0);
        check("bp_e100_led_f2", data_led, 0);
        tick(33);                                        // E133: F3 swapped in
        check("bp_e133_ss", slot_start, 1);
        check("bp_e133_led_f3", data_led, 1);

        // Mid-frame clear with a frame pending.
        src_q.push_back(16'h00FF);
        n = 0;
        while (!(led_idx == 4'd7 && slot_start) && n < 40) begin
            tick();
            n++;
        end
        check("clr_reach_idx7", (led_idx == 4'd7 && slot_start), 1);
        check("clr_pending_full", frame_if.frame_ready, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_led", data_led, 0);
        check("clr_ready", frame_if.frame_ready, 1);
        check("clr_idx", led_idx, 0);
        tick(5);
        check("clr_stays_idle", busy, 0);
        src_q.push_back(16'h0002);
        wait_busy("clr_next_start");
        check("clr_next_idx", led_idx, 0);
        check("clr_next_ss", slot_start, 1);
        check("clr_next_led0", data_led, 0);
        tick(2);
        check("clr_next_idx1", led_idx, 1);
        check("clr_next_led1", data_led, 1);

        // Mid-frame reset.
        tick(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_ready", frame_if.frame_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_led", data_led, 0);
        check("mrst_idx", led_idx, 0);
        check("mrst_ss", slot_start, 0);
        check("mrst_done", frame_done, 0);
        fd_cnt   = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (frame_done) fd_cnt++;
            if (busy) busy_cnt++;
        end
        check("mrst_no_frame_done", fd_cnt, 0);
        check("mrst_stays_idle", busy_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
